// File: rtl/intersection_phase_scheduler_pkg.sv
// Shared definitions for the intersection phase scheduler: phase encoding,
// lamp bit ordering, default durations and small helper functions.
package intersection_phase_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_MAIN_GREEN  = 3'd0,
        ST_MAIN_YELLOW = 3'd1,
        ST_ALL_RED_1   = 3'd2,
        ST_SIDE_GREEN  = 3'd3,
        ST_SIDE_YELLOW = 3'd4,
        ST_ALL_RED_2   = 3'd5,
        ST_PED_WALK    = 3'd6
    } phase_e;

    // Lamp vector bit positions, MSB first: main R/Y/G, side R/Y/G, walk.
    localparam int LAMP_W           = 7;
    localparam int LAMP_MAIN_RED    = 6;
    localparam int LAMP_MAIN_YELLOW = 5;
    localparam int LAMP_MAIN_GREEN  = 4;
    localparam int LAMP_SIDE_RED    = 3;
    localparam int LAMP_SIDE_YELLOW = 2;
    localparam int LAMP_SIDE_GREEN  = 1;
    localparam int LAMP_WALK        = 0;

    localparam int DEF_CL_PER_TIME     = 100;
    localparam int DEF_MAIN_GREEN_TIME = 15;
    localparam int DEF_SIDE_GREEN_TIME = 10;
    localparam int DEF_YELLOW_TIME     = 3;
    localparam int DEF_ALL_RED_TIME    = 2;
    localparam int DEF_PED_WALK_TIME   = 8;

    function automatic int dur_max(input int a, input int b, input int c,
                                   input int d, input int e);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (e > m) m = e;
        return m;
    endfunction

    // Exactly one lamp per road; the unused encoding shows red on both roads.
    function automatic logic [LAMP_W-1:0] lamp_decode(input phase_e st);
        logic [LAMP_W-1:0] l;
        l = '0;
        case (st)
            ST_MAIN_GREEN: begin
                l[LAMP_MAIN_GREEN] = 1'b1;
                l[LAMP_SIDE_RED]   = 1'b1;
            end
            ST_MAIN_YELLOW: begin
                l[LAMP_MAIN_YELLOW] = 1'b1;
                l[LAMP_SIDE_RED]    = 1'b1;
            end
            ST_SIDE_GREEN: begin
                l[LAMP_MAIN_RED]   = 1'b1;
                l[LAMP_SIDE_GREEN] = 1'b1;
            end
            ST_SIDE_YELLOW: begin
                l[LAMP_MAIN_RED]    = 1'b1;
                l[LAMP_SIDE_YELLOW] = 1'b1;
            end
            ST_PED_WALK: begin
                l[LAMP_MAIN_RED] = 1'b1;
                l[LAMP_SIDE_RED] = 1'b1;
                l[LAMP_WALK]     = 1'b1;
            end
            default: begin
                l[LAMP_MAIN_RED] = 1'b1;
                l[LAMP_SIDE_RED] = 1'b1;
            end
        endcase
        return l;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the system clock down to a one-cycle tick every CL_PER_TIME
// enabled cycles. The count freezes while en is low so no period is
// shortened or stretched across a pause.
module tick_prescaler #(
    parameter int CL_PER_TIME = 100
) (
    input  logic clk,
    input  logic rstb,
    input  logic en,
    output logic sec_tick
);

    localparam int CW = (CL_PER_TIME > 1) ? $clog2(CL_PER_TIME) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CL_PER_TIME - 1);

    logic [CW-1:0] cnt;

    // Free-running wrap counter, advancing only while enabled.
    always_ff @(posedge clk) begin
        if (rstb) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign sec_tick = en && (cnt == CNT_LAST);

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Phase sequencer for a main/side road intersection with a pedestrian
// crossing over the main road.
//
//   state          | meaning
//   MAIN_GREEN     | main road green, rests here until demand
//   MAIN_YELLOW    | main road clearing
//   ALL_RED_1      | clearance before side or pedestrian phase
//   SIDE_GREEN     | side road green
//   SIDE_YELLOW    | side road clearing
//   ALL_RED_2      | clearance before returning to main green
//   PED_WALK       | pedestrians cross the main road
module intersection_phase_scheduler
    import intersection_phase_scheduler_pkg::*;
#(
    parameter int CL_PER_TIME     = DEF_CL_PER_TIME,
    parameter int MAIN_GREEN_TIME = DEF_MAIN_GREEN_TIME,
    parameter int SIDE_GREEN_TIME = DEF_SIDE_GREEN_TIME,
    parameter int YELLOW_TIME     = DEF_YELLOW_TIME,
    parameter int ALL_RED_TIME    = DEF_ALL_RED_TIME,
    parameter int PED_WALK_TIME   = DEF_PED_WALK_TIME,
    parameter int CNT_W = $clog2(dur_max(MAIN_GREEN_TIME, SIDE_GREEN_TIME,
                                         YELLOW_TIME, ALL_RED_TIME,
                                         PED_WALK_TIME) + 1)
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             en,
    input  logic             ped_req,
    input  logic             side_sensor,
    output logic             ped_ack,
    output logic             main_red,
    output logic             main_yellow,
    output logic             main_green,
    output logic             side_red,
    output logic             side_yellow,
    output logic             side_green,
    output logic             walk,
    output logic [2:0]       phase,
    output logic [CNT_W-1:0] remain
);

    localparam logic [CNT_W-1:0] REMAIN_ONE = CNT_W'(1);

    phase_e            state;
    phase_e            state_nxt;
    logic              adv;
    logic              enter_walk;
    logic              ped_pending;
    logic              sec_tick;
    logic [LAMP_W-1:0] lamps;

    function automatic logic [CNT_W-1:0] dur_of(input phase_e st);
        case (st)
            ST_MAIN_GREEN:  return CNT_W'(MAIN_GREEN_TIME);
            ST_MAIN_YELLOW: return CNT_W'(YELLOW_TIME);
            ST_SIDE_YELLOW: return CNT_W'(YELLOW_TIME);
            ST_ALL_RED_1:   return CNT_W'(ALL_RED_TIME);
            ST_ALL_RED_2:   return CNT_W'(ALL_RED_TIME);
            ST_SIDE_GREEN:  return CNT_W'(SIDE_GREEN_TIME);
            ST_PED_WALK:    return CNT_W'(PED_WALK_TIME);
            default:        return CNT_W'(MAIN_GREEN_TIME);
        endcase
    endfunction

    tick_prescaler #(
        .CL_PER_TIME (CL_PER_TIME)
    ) u_tick_prescaler (
        .clk      (clk),
        .rstb     (rstb),
        .en       (en),
        .sec_tick (sec_tick)
    );

    // Next-phase selection; phases only change on a tick that ends the phase.
    // Timed phases use remain<=1 so a zero duration cannot wedge the FSM.
    always_comb begin
        adv       = 1'b0;
        state_nxt = state;
        if (sec_tick) begin
            case (state)
                ST_MAIN_GREEN: begin
                    if (remain <= REMAIN_ONE && (side_sensor || ped_pending)) begin
                        adv       = 1'b1;
                        state_nxt = ST_MAIN_YELLOW;
                    end
                end
                ST_MAIN_YELLOW: begin
                    if (remain <= REMAIN_ONE) begin
                        adv       = 1'b1;
                        state_nxt = ST_ALL_RED_1;
                    end
                end
                ST_ALL_RED_1: begin
                    if (remain <= REMAIN_ONE) begin
                        adv       = 1'b1;
                        state_nxt = ped_pending ? ST_PED_WALK : ST_SIDE_GREEN;
                    end
                end
                ST_PED_WALK: begin
                    if (remain <= REMAIN_ONE) begin
                        adv       = 1'b1;
                        state_nxt = side_sensor ? ST_SIDE_GREEN : ST_ALL_RED_2;
                    end
                end
                ST_SIDE_GREEN: begin
                    if (remain <= REMAIN_ONE) begin
                        adv       = 1'b1;
                        state_nxt = ST_SIDE_YELLOW;
                    end
                end
                ST_SIDE_YELLOW: begin
                    if (remain <= REMAIN_ONE) begin
                        adv       = 1'b1;
                        state_nxt = ST_ALL_RED_2;
                    end
                end
                ST_ALL_RED_2: begin
                    if (remain <= REMAIN_ONE) begin
                        adv       = 1'b1;
                        state_nxt = ST_MAIN_GREEN;
                    end
                end
                default: begin
                    adv       = 1'b1;
                    state_nxt = ST_MAIN_GREEN;
                end
            endcase
        end
        enter_walk = adv && (state_nxt == ST_PED_WALK);
    end

    // Phase register, seconds timer, pedestrian latch and walk acknowledge.
    // The walk-entry clear wins over a same-cycle button press so a press
    // that coincides with the start of the walk is not carried over.
    always_ff @(posedge clk) begin
        if (rstb) begin
            state       <= ST_MAIN_GREEN;
            remain      <= CNT_W'(MAIN_GREEN_TIME);
            ped_pending <= 1'b0;
            ped_ack     <= 1'b0;
        end else begin
            ped_ack <= enter_walk;
            if (adv) begin
                state  <= state_nxt;
                remain <= dur_of(state_nxt);
            end else if (sec_tick && remain != '0) begin
                remain <= remain - 1'b1;
            end
            if (enter_walk) begin
                ped_pending <= 1'b0;
            end else if (en && ped_req && state != ST_PED_WALK) begin
                ped_pending <= 1'b1;
            end
        end
    end

    assign lamps       = lamp_decode(state);
    assign main_red    = lamps[LAMP_MAIN_RED];
    assign main_yellow = lamps[LAMP_MAIN_YELLOW];
    assign main_green  = lamps[LAMP_MAIN_GREEN];
    assign side_red    = lamps[LAMP_SIDE_RED];
    assign side_yellow = lamps[LAMP_SIDE_YELLOW];
    assign side_green  = lamps[LAMP_SIDE_GREEN];
    assign walk        = lamps[LAMP_WALK];
    assign phase       = state;

endmodule
